axi_mem_slave: RTL

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory slave serving one burst at a time, round-robin AW/AR grant.
// Latency: first RVALID 2 cycles after AR handshake; BVALID 1 cycle after the final W beat.
// Backpressure: none by default; define AXI_MEM_SLAVE_BP_EN for LFSR-driven WREADY/RVALID stalls.
module axi_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int MA_W   = $clog2(MEM_DEPTH);
    localparam int IDX_W  = MA_W + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t            state;
    logic              prefer_wr;
    logic [7:0]        len_q;
    logic [7:0]        beat_cnt;
    logic [IDX_W-1:0]  idx;
    logic [8:0]        neg_cnt;
    logic              wr_err;
    logic              stall;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              aw_gnt, ar_gnt, aw_hs, ar_hs, w_hs, r_hs;
    logic              in_range, rd_load, last_beat, beat_err;
    logic [MA_W-1:0]   mem_idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [8:0]        neg_nxt;
    logic [ADDR_W-1:0] sel_word, base_word, below_words, above_words;

`ifdef AXI_MEM_SLAVE_BP_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign aw_gnt = S_AXI_AWVALID && (!S_AXI_ARVALID || prefer_wr);
    assign ar_gnt = S_AXI_ARVALID && (!S_AXI_AWVALID || !prefer_wr);

    assign S_AXI_AWREADY = !rst && (state == IDLE) && aw_gnt;
    assign S_AXI_ARREADY = !rst && (state == IDLE) && ar_gnt;
    assign S_AXI_WREADY  = !rst && (state == WR_DATA) && !stall;

    assign aw_hs = S_AXI_AWREADY && S_AXI_AWVALID;
    assign ar_hs = S_AXI_ARREADY && S_AXI_ARVALID;
    assign w_hs  = S_AXI_WREADY && S_AXI_WVALID;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;

    // Word offsets relative to BASE_ADDR; sub-word address bits drop out in the shift.
    assign sel_word    = (aw_gnt ? S_AXI_AWADDR : S_AXI_ARADDR) >> SHIFT;
    assign base_word   = BASE_ADDR >> SHIFT;
    assign below_words = base_word - sel_word;
    assign above_words = sel_word - base_word;

    // neg_cnt counts beats still below BASE_ADDR; idx saturates at MEM_DEPTH once past the end.
    assign in_range  = (neg_cnt == 9'd0) && (idx < IDX_W'(MEM_DEPTH));
    assign mem_idx   = idx[MA_W-1:0];
    assign last_beat = (beat_cnt == len_q);
    assign beat_err  = !in_range || (S_AXI_WLAST != last_beat);

    always_comb begin
        idx_nxt = idx;
        neg_nxt = neg_cnt;
        if (neg_cnt != 9'd0)
            neg_nxt = neg_cnt - 9'd1;
        else if (idx < IDX_W'(MEM_DEPTH))
            idx_nxt = idx + IDX_W'(1);
    end

    // A new read beat is fetched when the output register is empty or being drained mid-burst.
    assign rd_load = !rst && !stall &&
                     ((state == RD_ADDR) ||
                      ((state == RD_DATA) && (!S_AXI_RVALID || (S_AXI_RREADY && !S_AXI_RLAST))));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prefer_wr    <= 1'b1;
            len_q        <= 8'd0;
            beat_cnt     <= 8'd0;
            idx          <= '0;
            neg_cnt      <= 9'd0;
            wr_err       <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RLAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs || ar_hs) begin
                        len_q     <= aw_hs ? S_AXI_AWLEN : S_AXI_ARLEN;
                        beat_cnt  <= 8'd0;
                        wr_err    <= 1'b0;
                        prefer_wr <= ar_hs;
                        state     <= aw_hs ? WR_DATA : RD_ADDR;
                        if (sel_word < base_word) begin
                            idx     <= '0;
                            neg_cnt <= (below_words > ADDR_W'(256)) ? 9'd256 : below_words[8:0];
                        end else begin
                            neg_cnt <= 9'd0;
                            idx     <= (above_words >= ADDR_W'(MEM_DEPTH)) ? IDX_W'(MEM_DEPTH)
                                                                           : above_words[IDX_W-1:0];
                        end
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        idx      <= idx_nxt;
                        neg_cnt  <= neg_nxt;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_err)
                            wr_err <= 1'b1;
                        if (last_beat) begin
                            state        <= WR_RESP;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (wr_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        S_AXI_BRESP  <= RESP_OKAY;
                        state        <= IDLE;
                    end
                end
                RD_ADDR, RD_DATA: begin
                    if (r_hs && S_AXI_RLAST) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        S_AXI_RRESP  <= RESP_OKAY;
                        state        <= IDLE;
                    end else if (rd_load) begin
                        S_AXI_RVALID <= 1'b1;
                        S_AXI_RRESP  <= in_range ? RESP_OKAY : RESP_SLVERR;
                        S_AXI_RLAST  <= last_beat;
                        beat_cnt     <= beat_cnt + 8'd1;
                        idx          <= idx_nxt;
                        neg_cnt      <= neg_nxt;
                        state        <= RD_DATA;
                    end else if (r_hs) begin
                        S_AXI_RVALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; only in-range beats touch it.
    always_ff @(posedge clk) begin
        if (w_hs && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b])
                    mem[mem_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (rd_load)
            S_AXI_RDATA <= in_range ? mem[mem_idx] : '0;
    end

endmodule
